auth_usb_ctrl_tx: RTL and testbench

- Downstream stage of the authentication initiator. Captures one authentication request (USB control-transfer fields plus header and payload) when the initiator raises its message-valid strobe.
- Serialises the request onto a byte-wide link interface: an 8-byte SETUP packet, then, for host-to-device requests, the DATA stage.
- Waits for link completion under the timeout supplied by the initiator, then returns a one-cycle acknowledge, which is the initiator's Ack_in.

---
 rtl/auth_usb_ctrl_tx_pkg.sv | 40 ++++
 rtl/auth_usb_ctrl_tx_if.sv | 40 ++++
 rtl/auth_usb_ctrl_tx_serializer.sv | 49 ++++
 rtl/auth_usb_ctrl_tx.sv | 187 ++++++++++++++++++
 tb/tb_auth_usb_ctrl_tx.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/auth_usb_ctrl_tx_pkg.sv
// Shared definitions for the authentication request transmitter:
// state encoding, SETUP packet layout and message sizing.
package auth_usb_ctrl_tx_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 32;
  localparam int SIZE_OF_HEADER_IN_BYTES = SIZE_OF_HEADER_VARS / 8;
  localparam int MSG_LEN                 = 64;

  localparam int TX_HDR_BYTES     = SIZE_OF_HEADER_IN_BYTES;
  localparam int TX_PAYLOAD_BYTES = MSG_LEN - SIZE_OF_HEADER_IN_BYTES;

  localparam int SETUP_LEN   = 8;
  localparam int USB_DIR_BIT = 7;

  localparam int SIZE_OF_STATES_TX = 6;

  typedef enum logic [SIZE_OF_STATES_TX-1:0] {
    ST_IDLE        = 6'b000001,
    ST_SETUP       = 6'b000010,
    ST_DATA        = 6'b000100,
    ST_WAIT_STATUS = 6'b001000,
    ST_DONE        = 6'b010000,
    ST_RELEASE     = 6'b100000
  } tx_state_t;

  // Standard USB SETUP layout; wValue and wIndex are always sent as zero.
  function automatic logic [7:0] setup_byte(input logic [2:0]  idx,
                                            input logic [7:0]  req_type,
                                            input logic [7:0]  req_code,
                                            input logic [15:0] req_len);
    case (idx)
      3'd0:    setup_byte = req_type;
      3'd1:    setup_byte = req_code;
      3'd6:    setup_byte = req_len[7:0];
      3'd7:    setup_byte = req_len[15:8];
      default: setup_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/auth_usb_ctrl_tx_if.sv
// Request and byte-link signals of the transmitter; the slave modport is the
// transmitter's view, the master modport is the initiator/link side.
interface auth_usb_ctrl_tx_if
  import auth_usb_ctrl_tx_pkg::*;
#(
  parameter int HDR_BYTES     = TX_HDR_BYTES,
  parameter int PAYLOAD_BYTES = TX_PAYLOAD_BYTES
) ();

  logic                       msg_valid;
  logic [7:0]                 bmRequestType;
  logic [7:0]                 bRequest;
  logic [15:0]                wLength;
  logic [31:0]                current_timeout;
  logic [8*HDR_BYTES-1:0]     header;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic                       tx_ready;
  logic                       link_done;
  logic                       link_err;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_last;
  logic                       msg_ack;
  logic                       busy;
  logic                       timeout_err;
  logic                       xfer_err;

  modport master (
    output msg_valid, bmRequestType, bRequest, wLength, current_timeout,
           header, payload, tx_ready, link_done, link_err,
    input  tx_data, tx_valid, tx_last, msg_ack, busy, timeout_err, xfer_err
  );

  modport slave (
    input  msg_valid, bmRequestType, bRequest, wLength, current_timeout,
           header, payload, tx_ready, link_done, link_err,
    output tx_data, tx_valid, tx_last, msg_ack, busy, timeout_err, xfer_err
  );

endinterface

// File: rtl/auth_usb_ctrl_tx_serializer.sv
// Counter-driven byte mux over the {payload,header} vector for the DATA stage,
// advancing on valid&&ready and flagging the final byte of len.
module auth_byte_serializer
  import auth_usb_ctrl_tx_pkg::*;
#(
  parameter int HDR_BYTES     = TX_HDR_BYTES,
  parameter int PAYLOAD_BYTES = TX_PAYLOAD_BYTES,
  parameter int CNT_W         = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   load,
  input  logic [CNT_W-1:0]                       len,
  input  logic [8*(HDR_BYTES+PAYLOAD_BYTES)-1:0] data,
  input  logic                                   valid,
  input  logic                                   ready,
  output logic [7:0]                             byte_out,
  output logic                                   last,
  output logic                                   done
);

  localparam int TOTAL_BYTES = HDR_BYTES + PAYLOAD_BYTES;

  logic [CNT_W-1:0] idx;

  assign last = (idx == len - CNT_W'(1));
  assign done = valid && ready && last;

  // The index parks on the last byte; the next load rewinds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (valid && ready && !last) begin
      idx <= idx + CNT_W'(1);
    end
  end

  always_comb begin
    byte_out = '0;
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      if (idx == CNT_W'(i)) begin
        byte_out = data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/auth_usb_ctrl_tx.sv
// Transmit stage of the authentication initiator: captures one request, sends
// SETUP and optional DATA over the byte link, then waits for status and acks.
module auth_usb_ctrl_tx
  import auth_usb_ctrl_tx_pkg::*;
#(
  parameter int HDR_BYTES     = TX_HDR_BYTES,
  parameter int PAYLOAD_BYTES = TX_PAYLOAD_BYTES,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               reset,
  auth_usb_ctrl_tx_if.slave bus
);

  localparam int         TOTAL_BYTES = HDR_BYTES + PAYLOAD_BYTES;
  localparam logic [2:0] SETUP_LAST  = 3'(SETUP_LEN - 1);

  tx_state_t state, state_next;

  logic [7:0]               req_type;
  logic [7:0]               req_code;
  logic [15:0]              req_len;
  logic [31:0]              req_timeout;
  logic [8*TOTAL_BYTES-1:0] req_data;
  logic [CNT_W-1:0]         data_len;
  logic [CNT_W-1:0]         len_clamped;

  logic [2:0]  setup_idx;
  logic [31:0] wait_cnt;

  logic tx_valid_q;
  logic msg_ack_q;
  logic timeout_err_q;
  logic xfer_err_q;

  logic       capture;
  logic       accept;
  logic       setup_last;
  logic       timeout_hit;
  logic       set_xfer_err;
  logic       set_timeout_err;
  logic [7:0] tx_data_c;
  logic       tx_last_c;

  logic       ser_valid;
  logic [7:0] ser_byte;
  logic       ser_last;
  logic       ser_done;

  assign capture     = (state == ST_IDLE) && bus.msg_valid;
  assign accept      = tx_valid_q && bus.tx_ready;
  assign setup_last  = (setup_idx == SETUP_LAST);
  assign ser_valid   = tx_valid_q && (state == ST_DATA);
  assign timeout_hit = (req_timeout != 32'd0) && (wait_cnt == req_timeout - 32'd1);

  always_comb begin
    if ({16'd0, bus.wLength} > 32'(TOTAL_BYTES)) begin
      len_clamped = CNT_W'(TOTAL_BYTES);
    end else begin
      len_clamped = CNT_W'(bus.wLength);
    end
  end

  // Request snapshot; later input changes cannot disturb a transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_type    <= '0;
      req_code    <= '0;
      req_len     <= '0;
      req_timeout <= '0;
      req_data    <= '0;
      data_len    <= '0;
    end else if (capture) begin
      req_type    <= bus.bmRequestType;
      req_code    <= bus.bRequest;
      req_len     <= bus.wLength;
      req_timeout <= bus.current_timeout;
      req_data    <= {bus.payload, bus.header};
      data_len    <= len_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      setup_idx     <= '0;
      wait_cnt      <= '0;
      tx_valid_q    <= 1'b0;
      msg_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      xfer_err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        setup_idx <= '0;
      end else if ((state == ST_SETUP) && accept && !setup_last) begin
        setup_idx <= setup_idx + 3'd1;
      end
      wait_cnt      <= (state == ST_WAIT_STATUS) ? wait_cnt + 32'd1 : 32'd0;
      tx_valid_q    <= (state_next == ST_SETUP) || (state_next == ST_DATA);
      msg_ack_q     <= (state_next == ST_DONE);
      timeout_err_q <= set_timeout_err;
      xfer_err_q    <= set_xfer_err;
    end
  end

  // A link error wins over a byte handshake in the same cycle.
  always_comb begin
    state_next      = state;
    set_xfer_err    = 1'b0;
    set_timeout_err = 1'b0;
    tx_data_c       = 8'h00;
    tx_last_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.msg_valid) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        tx_data_c = setup_byte(setup_idx, req_type, req_code, req_len);
        tx_last_c = setup_last;
        if (bus.link_err) begin
          set_xfer_err = 1'b1;
          state_next   = ST_DONE;
        end else if (accept && setup_last) begin
          if (req_type[USB_DIR_BIT] || (data_len == '0)) state_next = ST_WAIT_STATUS;
          else                                           state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_data_c = ser_byte;
        tx_last_c = ser_last;
        if (bus.link_err) begin
          set_xfer_err = 1'b1;
          state_next   = ST_DONE;
        end else if (ser_done) begin
          state_next = ST_WAIT_STATUS;
        end
      end
      ST_WAIT_STATUS: begin
        if (bus.link_done) begin
          state_next = ST_DONE;
        end else if (bus.link_err) begin
          set_xfer_err = 1'b1;
          state_next   = ST_DONE;
        end else if (timeout_hit) begin
          set_timeout_err = 1'b1;
          state_next      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.msg_valid) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  auth_byte_serializer #(
    .HDR_BYTES     (HDR_BYTES),
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .CNT_W         (CNT_W)
  ) u_serializer (
    .clk      (clk),
    .reset    (reset),
    .load     (capture),
    .len      (data_len),
    .data     (req_data),
    .valid    (ser_valid),
    .ready    (bus.tx_ready),
    .byte_out (ser_byte),
    .last     (ser_last),
    .done     (ser_done)
  );

  assign bus.tx_data     = tx_data_c;
  assign bus.tx_last     = tx_last_c;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.msg_ack     = msg_ack_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.xfer_err    = xfer_err_q;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_auth_usb_ctrl_tx.sv
// Directed and randomized bench for auth_usb_ctrl_tx, checked against a
// byte-list model of the SETUP/DATA packets and a cycle model of the status wait.
module tb_auth_usb_ctrl_tx;

  localparam int HDR   = 4;
  localparam int PAY   = 60;
  localparam int TOTAL = HDR + PAY;
  localparam int INF   = 1 << 30;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  auth_usb_ctrl_tx_if #(.HDR_BYTES(HDR), .PAYLOAD_BYTES(PAY)) bus ();

  auth_usb_ctrl_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected link bytes as {last, byte}, straight from the request fields.
  task automatic buildExpected(input logic [7:0] rt, input logic [7:0] rq, input logic [15:0] wl,
                               input logic [31:0] hdr, input logic [8*PAY-1:0] pl);
    int n;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back({1'b0, rt});
    exp_q.push_back({1'b0, rq});
    for (int i = 0; i < 4; i++) exp_q.push_back(9'h000);
    exp_q.push_back({1'b0, wl[7:0]});
    exp_q.push_back({1'b1, wl[15:8]});
    n = (int'(wl) > TOTAL) ? TOTAL : int'(wl);
    if (!rt[7]) begin
      for (int i = 0; i < n; i++) begin
        b = (i < HDR) ? hdr[8*i +: 8] : pl[8*(i-HDR) +: 8];
        exp_q.push_back({(i == n - 1), b});
      end
    end
  endtask

  task automatic randPayload(output logic [8*PAY-1:0] p);
    for (int i = 0; i < PAY / 4; i++) p[32*i +: 32] = $urandom;
  endtask

  task automatic applyStimulus(input logic [7:0] rt, input logic [7:0] rq, input logic [15:0] wl,
                               input logic [31:0] to, input logic [31:0] hdr, input logic [8*PAY-1:0] pl);
    bus.bmRequestType   = rt;
    bus.bRequest        = rq;
    bus.wLength         = wl;
    bus.current_timeout = to;
    bus.header          = hdr;
    bus.payload         = pl;
    bus.msg_valid       = 1'b1;
    buildExpected(rt, rq, wl, hdr, pl);
  endtask

  task automatic scrambleInputs();
    logic [8*PAY-1:0] p;
    randPayload(p);
    bus.bmRequestType   = 8'($urandom);
    bus.bRequest        = 8'($urandom);
    bus.wLength         = 16'($urandom);
    bus.current_timeout = 32'($urandom_range(1, 3));
    bus.header          = $urandom;
    bus.payload         = p;
  endtask

  // Collects accepted bytes; returns at the first cycle with tx_valid low after
  // the packets, or early (stopped=1) when byte stop_idx is being presented.
  task automatic collectBytes(input int ready_mode, input int stop_idx, output bit stopped);
    bit         started;
    bit         prev_stall;
    logic [8:0] prev;
    started    = 1'b0;
    prev_stall = 1'b0;
    prev       = '0;
    stopped    = 1'b0;
    obs_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = (c % 2 == 0);
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        checkOutput("stall_valid", 64'(bus.tx_valid), 64'(1));
        checkOutput("stall_data", 64'({bus.tx_last, bus.tx_data}), 64'(prev));
      end
      if (bus.tx_valid) begin
        if (!started) begin
          started = 1'b1;
          scrambleInputs();
        end
        if (obs_q.size() == stop_idx) begin
          stopped = 1'b1;
          return;
        end
        prev       = {bus.tx_last, bus.tx_data};
        prev_stall = !bus.tx_ready;
        if (bus.tx_ready) obs_q.push_back(prev);
      end else begin
        prev_stall = 1'b0;
        if (started) return;
        if (c > 20) begin
          checkOutput("start_timeout", 64'(0), 64'(1));
          return;
        end
      end
    end
    checkOutput("collect_timeout", 64'(0), 64'(1));
  endtask

  task automatic compareBytes(input string tag, input int n);
    checkOutput({tag, "_count"}, 64'(obs_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
  endtask

  // Drives link events at cycle offsets from the current cycle (-1 = never)
  // and checks when ack and error pulses appear.
  task automatic waitStatus(input int done_at, input int err_at, input logic [31:0] to, input int budget);
    int ev, ack_k, to_k, xf_k, exp_ack, exp_to, exp_xf;
    ack_k = -1; to_k = -1; xf_k = -1;
    exp_ack = -1; exp_to = -1; exp_xf = -1;
    ev = INF;
    if (done_at >= 0) ev = done_at;
    if (err_at >= 0 && err_at < ev) ev = err_at;
    if (to != 0 && int'(to) - 1 < ev) ev = int'(to) - 1;
    if (ev != INF) begin
      exp_ack = ev + 1;
      if (done_at != ev) begin
        if (err_at == ev) exp_xf = ev + 1;
        else              exp_to = ev + 1;
      end
    end
    for (int k = 0; k <= budget; k++) begin
      bus.link_done = (k == done_at);
      bus.link_err  = (k == err_at);
      @(negedge clk);
      bus.link_done = 1'b0;
      bus.link_err  = 1'b0;
      if (bus.timeout_err && to_k < 0) to_k = k + 1;
      if (bus.xfer_err && xf_k < 0)    xf_k = k + 1;
      if (bus.msg_ack) begin
        ack_k = k + 1;
        break;
      end
    end
    checkOutput("ack_cycle", 64'(ack_k), 64'(exp_ack));
    checkOutput("timeout_cycle", 64'(to_k), 64'(exp_to));
    checkOutput("xfer_cycle", 64'(xf_k), 64'(exp_xf));
  endtask

  task automatic finishRequest();
    @(negedge clk);
    checkOutput("ack_once", 64'(bus.msg_ack), 64'(0));
    checkOutput("err_pulse_end", 64'({bus.timeout_err, bus.xfer_err}), 64'(0));
    checkOutput("release_busy", 64'(bus.busy), 64'(1));
    checkOutput("release_no_tx", 64'(bus.tx_valid), 64'(0));
    bus.msg_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 64'(bus.busy), 64'(0));
    checkOutput("idle_no_tx", 64'(bus.tx_valid), 64'(0));
  endtask

  initial begin
    logic [8*PAY-1:0] ramp;
    logic [8*PAY-1:0] pl;
    logic [15:0]      wl_pick [9];
    logic [7:0]       rt;
    logic [15:0]      wl;
    logic [31:0]      to;
    int               done_at, err_at, mode;
    bit               stopped;

    reset               = 1'b1;
    bus.msg_valid       = 1'b0;
    bus.bmRequestType   = '0;
    bus.bRequest        = '0;
    bus.wLength         = '0;
    bus.current_timeout = '0;
    bus.header          = '0;
    bus.payload         = '0;
    bus.tx_ready        = 1'b0;
    bus.link_done       = 1'b0;
    bus.link_err        = 1'b0;
    for (int i = 0; i < PAY; i++) ramp[8*i +: 8] = 8'(i + 5);

    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
    checkOutput("rst_tx_last", 64'(bus.tx_last), 64'(0));
    checkOutput("rst_tx_data", 64'(bus.tx_data), 64'(0));
    checkOutput("rst_msg_ack", 64'(bus.msg_ack), 64'(0));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_errs", 64'({bus.timeout_err, bus.xfer_err}), 64'(0));
    reset = 1'b0;

    $display("[TB] IN request, no DATA stage");
    @(negedge clk);
    applyStimulus(8'h80, 8'd24, 16'd168, 32'd0, 32'h0403_0201, ramp);
    collectBytes(0, -1, stopped);
    compareBytes("in_req", exp_q.size());
    waitStatus(10, -1, 32'd0, 50);
    finishRequest();

    $display("[TB] OUT request, 64 data bytes");
    applyStimulus(8'h00, 8'd25, 16'd2052, 32'd0, 32'h0403_0201, ramp);
    collectBytes(0, -1, stopped);
    compareBytes("out_req", 72);
    waitStatus(3, -1, 32'd0, 50);
    finishRequest();

    $display("[TB] OUT request with toggling tx_ready");
    applyStimulus(8'h00, 8'd25, 16'd2052, 32'd0, 32'h0403_0201, ramp);
    collectBytes(1, -1, stopped);
    compareBytes("bp_req", 72);
    waitStatus(0, -1, 32'd0, 50);
    finishRequest();

    $display("[TB] timeout of 20 cycles");
    applyStimulus(8'h80, 8'd24, 16'd0, 32'd20, 32'h0, ramp);
    collectBytes(0, -1, stopped);
    compareBytes("to_req", 8);
    waitStatus(-1, -1, 32'd20, 100);
    finishRequest();

    $display("[TB] timeout disabled");
    applyStimulus(8'h80, 8'd24, 16'd0, 32'd0, 32'h0, ramp);
    collectBytes(0, -1, stopped);
    waitStatus(-1, -1, 32'd0, 1000);
    waitStatus(0, -1, 32'd0, 10);
    finishRequest();

    $display("[TB] link_done and link_err together");
    applyStimulus(8'h00, 8'd7, 16'd0, 32'd30, 32'h0, ramp);
    collectBytes(2, -1, stopped);
    compareBytes("zero_len", 8);
    waitStatus(4, 4, 32'd30, 50);
    finishRequest();

    $display("[TB] link_err while waiting");
    applyStimulus(8'h80, 8'd9, 16'd4, 32'd20, 32'h0, ramp);
    collectBytes(0, -1, stopped);
    waitStatus(-1, 2, 32'd20, 50);
    finishRequest();

    $display("[TB] link_err during DATA byte 3");
    applyStimulus(8'h00, 8'd25, 16'd20, 32'd0, 32'hA1B2_C3D4, ramp);
    collectBytes(0, 11, stopped);
    checkOutput("err_stop_reached", 64'(stopped), 64'(1));
    bus.link_err = 1'b1;
    @(negedge clk);
    bus.link_err = 1'b0;
    checkOutput("err_tx_valid", 64'(bus.tx_valid), 64'(0));
    checkOutput("err_msg_ack", 64'(bus.msg_ack), 64'(1));
    checkOutput("err_xfer_err", 64'(bus.xfer_err), 64'(1));
    checkOutput("err_timeout_err", 64'(bus.timeout_err), 64'(0));
    compareBytes("err_bytes", 11);
    finishRequest();

    $display("[TB] reset at byte 10 with msg_valid held");
    applyStimulus(8'h00, 8'd25, 16'd2052, 32'd0, 32'h0403_0201, ramp);
    collectBytes(0, 10, stopped);
    checkOutput("rst_stop_reached", 64'(stopped), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_tx_valid", 64'(bus.tx_valid), 64'(0));
    checkOutput("mid_rst_tx_last", 64'(bus.tx_last), 64'(0));
    checkOutput("mid_rst_tx_data", 64'(bus.tx_data), 64'(0));
    checkOutput("mid_rst_msg_ack", 64'(bus.msg_ack), 64'(0));
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("mid_rst_errs", 64'({bus.timeout_err, bus.xfer_err}), 64'(0));
    applyStimulus(8'h00, 8'd25, 16'd2052, 32'd0, 32'h0403_0201, ramp);
    reset = 1'b0;
    collectBytes(0, -1, stopped);
    compareBytes("after_rst", 72);
    waitStatus(2, -1, 32'd0, 50);
    finishRequest();

    $display("[TB] randomized requests");
    wl_pick = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd5, 16'd63, 16'd64, 16'd65, 16'd300};
    for (int r = 0; r < 10; r++) begin
      randPayload(pl);
      rt = 8'($urandom);
      wl = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200)) : wl_pick[$urandom_range(0, 8)];
      to = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(3, 30)) : 32'd0;
      done_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      err_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      if (to == 0 && done_at < 0 && err_at < 0) done_at = 5;
      mode = int'($urandom_range(0, 2));
      applyStimulus(rt, 8'($urandom), wl, to, $urandom, pl);
      collectBytes(mode, -1, stopped);
      compareBytes($sformatf("rand%0d", r), exp_q.size());
      waitStatus(done_at, err_at, to, 100);
      finishRequest();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
